// File: rtl/inst_sram_ctrl_pkg.sv
// Shared types and constants for the instruction SRAM controller:
// FSM state encoding, NOP returned for faulting lines, line/tag widths.
package inst_sram_ctrl_pkg;
    localparam int          ADDR_W   = 64;
    localparam int          LINE_W   = 64;
    localparam int          TAG_W    = ADDR_W - 3;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:3], 3'b000};
    endfunction
endpackage

// File: rtl/inst_line_buf.sv
// Single-line instruction buffer: tag/data/error/valid storage, hit compare
// and 32-bit word select (faulting lines read back as NOP).
module inst_line_buf
    import inst_sram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              install_i,
    input  logic              invalidate_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic              wr_err_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic              rd_word_sel_i,
    output logic              hit_o,
    output logic [31:0]       rd_word_o,
    output logic              rd_err_o
);
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] data_q;
    logic              err_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (install_i) begin
            tag_q   <= wr_tag_i;
            data_q  <= wr_data_i;
            err_q   <= wr_err_i;
            valid_q <= 1'b1;
        end else if (invalidate_i) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o     = valid_q && (tag_q == rd_tag_i);
    assign rd_word_o = err_q ? NOP_INST : (rd_word_sel_i ? data_q[63:32] : data_q[31:0]);
    assign rd_err_o  = err_q;
endmodule

// File: rtl/inst_sram_ctrl.sv
// Instruction fetch controller: line-buffer hits return next cycle, misses
// fetch one 8-byte line over the bus. Define INST_LINE_BUF_EN to keep the line.
module inst_sram_ctrl
    import inst_sram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              inst_sram_en,
    input  logic [7:0]        inst_sram_we,
    input  logic [63:0]       inst_sram_addr,
    input  logic [63:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    output logic              inst_fault,
    output logic              stallreq,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [63:0]       mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    input  logic              mem_resp_err
);
    state_e      state_q;
    logic        flushed_q;
    logic        req_valid_q;
    logic [63:0] req_addr_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        req, lookup, install, invalidate;
    logic        hit, buf_err;
    logic [31:0] buf_word;
    logic        unused_ok;

    assign unused_ok = ^{inst_sram_wdata, inst_sram_addr[1:0]};

    assign req     = inst_sram_en && (inst_sram_we == 8'h00);
    assign lookup  = (state_q == S_IDLE) && req && !flush;
    assign install = (state_q == S_WAIT) && mem_resp_valid && !flush;
`ifdef INST_LINE_BUF_EN
    assign invalidate = 1'b0;
`else
    // Without a persistent buffer each line is consumed by its replay hit.
    assign invalidate = lookup && hit;
`endif

    inst_line_buf u_line_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .install_i     (install),
        .invalidate_i  (invalidate),
        .wr_tag_i      (req_addr_q[63:3]),
        .wr_data_i     (mem_resp_data),
        .wr_err_i      (mem_resp_err),
        .rd_tag_i      (inst_sram_addr[63:3]),
        .rd_word_sel_i (inst_sram_addr[2]),
        .hit_o         (hit),
        .rd_word_o     (buf_word),
        .rd_err_o      (buf_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flushed_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        fault_q <= 1'b0;
                    end else if (lookup && hit) begin
                        rdata_q <= buf_word;
                        fault_q <= buf_err;
                    end else if (lookup) begin
                        state_q     <= S_REQ;
                        flushed_q   <= 1'b0;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= line_addr(inst_sram_addr);
                    end
                end
                S_REQ: begin
                    // A request already offered must complete; a flush only
                    // marks its response for discard.
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= (flushed_q || flush) ? S_DRAIN : S_WAIT;
                    end else if (flush) begin
                        flushed_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid)   state_q <= S_IDLE;
                    else if (flush)       state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (mem_resp_valid)   state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stallreq        = rst_n && ((state_q != S_IDLE) || (lookup && !hit));
    assign inst_sram_rdata = rdata_q;
    assign inst_fault      = fault_q;
    assign mem_req_valid   = req_valid_q;
    assign mem_req_addr    = req_addr_q;
endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Directed scoreboard bench for inst_sram_ctrl: hits, misses, error lines,
// bus back-pressure, flush in IDLE/WAIT and reset mid-fetch.
module tb_inst_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        inst_sram_en = 1'b0;
    logic [7:0]  inst_sram_we = '0;
    logic [63:0] inst_sram_addr = '0;
    logic [63:0] inst_sram_wdata = '0;
    logic [31:0] inst_sram_rdata;
    logic        inst_fault;
    logic        stallreq;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        mem_resp_err = 1'b0;

    typedef struct packed {
        logic [31:0] word;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    inst_sram_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_fault      (inst_fault),
        .stallreq        (stallreq),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .mem_resp_err    (mem_resp_err)
    );

    function automatic logic [63:0] line_data(input logic [63:0] la);
        if (la == 64'h8000_0000) return 64'h1111_2222_3333_4444;
        return {la[31:0] ^ 32'hA5A5_5A5A, ~la[31:0]};
    endfunction

    function automatic logic line_err(input logic [63:0] la);
        return la == 64'h8000_0100;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fetch held until stallreq drops, with a bus model answering any miss.
    task automatic fetch(input logic [63:0] a, input int rdy_dly, input int resp_dly,
                         input bit exp_miss);
        logic [63:0] la;
        logic [63:0] ld;
        exp_t        e;
        exp_t        got;
        int          stalls;
        int          waited;
        int          hs;
        int          reqs;
        bit          done;
        la     = {a[63:3], 3'b000};
        ld     = line_data(la);
        stalls = 0;
        waited = 0;
        hs     = -1;
        reqs   = 0;
        done   = 1'b0;
        e.fault = line_err(la);
        e.word  = e.fault ? 32'h0000_0013 : (a[2] ? ld[63:32] : ld[31:0]);
        sb.push_back(e);
        @(negedge clk);
        inst_sram_en   = 1'b1;
        inst_sram_we   = '0;
        inst_sram_addr = a;
        for (int c = 0; c < 100 && !done; c++) begin
            if (c > 0) @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
            mem_resp_err   = 1'b0;
            if (mem_req_valid) begin
                reqs++;
                chk("req_addr", mem_req_addr, la);
                if (waited >= rdy_dly) begin
                    mem_req_ready = 1'b1;
                    hs = c;
                end else begin
                    waited++;
                end
            end
            if (hs >= 0 && c == hs + 1 + resp_dly) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = ld;
                mem_resp_err   = e.fault;
            end
            #1;
            if (!stallreq) done = 1'b1;
            else stalls++;
        end
        chk("fetch_done", 64'(done), 64'd1);
        chk("stall_cycles", 64'(stalls), exp_miss ? 64'(rdy_dly + resp_dly + 3) : 64'd0);
        chk("bus_used", 64'(reqs != 0), 64'(exp_miss));
        @(negedge clk);
        inst_sram_en   = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        got = sb.pop_front();
        chk("rdata", 64'(inst_sram_rdata), 64'(got.word));
        chk("fault", 64'(inst_fault), 64'(got.fault));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", 64'(inst_sram_rdata), 64'd0);
        chk("rst_fault", 64'(inst_fault), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", mem_req_addr, 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fetch(64'h8000_0000, 0, 1, 1'b1);
`ifdef INST_LINE_BUF_EN
        fetch(64'h8000_0004, 0, 1, 1'b0);
`else
        fetch(64'h8000_0004, 0, 1, 1'b1);
`endif
        fetch(64'h8000_0100, 0, 1, 1'b1);

        // flush in IDLE: fault cleared, rdata held, no fetch started
        @(negedge clk);
        flush = 1'b1; inst_sram_en = 1'b1; inst_sram_addr = 64'h8000_0000;
        #1 chk("flush_idle_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        flush = 1'b0; inst_sram_en = 1'b0;
        chk("flush_idle_fault", 64'(inst_fault), 64'd0);
        chk("flush_idle_rdata", 64'(inst_sram_rdata), 64'h13);
        chk("flush_idle_noreq", 64'(mem_req_valid), 64'd0);

        // write-enabled access is not a fetch
        @(negedge clk);
        inst_sram_en = 1'b1; inst_sram_we = 8'h0F; inst_sram_addr = 64'h8000_0700;
        #1 chk("we_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        inst_sram_en = 1'b0; inst_sram_we = '0;
        chk("we_noreq", 64'(mem_req_valid), 64'd0);

        fetch(64'h8000_0504, 5, 1, 1'b1);

        // flush while waiting for a response; the stale beat lands in DRAIN
        @(negedge clk);
        inst_sram_en = 1'b1; inst_sram_addr = 64'h8000_0300;
        #1 chk("fw_miss_stall", 64'(stallreq), 64'd1);
        @(negedge clk);
        inst_sram_en = 1'b0;
        chk("fw_req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; flush = 1'b1;
        #1 chk("fw_wait_stall", 64'(stallreq), 64'd1);
        chk("fw_req_dropped", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1 chk("fw_drain_stall", 64'(stallreq), 64'd1);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1 chk("fw_idle_stall", 64'(stallreq), 64'd0);
        fetch(64'h8000_0300, 0, 1, 1'b1);
        fetch(64'h8000_0200, 0, 2, 1'b1);

        // reset in WAIT, then a late response that must be ignored
        @(negedge clk);
        inst_sram_en = 1'b1; inst_sram_addr = 64'h8000_0400;
        @(negedge clk);
        inst_sram_en = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; rst_n = 1'b0;
        #1;
        chk("rw_rdata", 64'(inst_sram_rdata), 64'd0);
        chk("rw_fault", 64'(inst_fault), 64'd0);
        chk("rw_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rw_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = line_data(64'h8000_0400);
        #1 chk("rw_stray_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("rw_stray_noreq", 64'(mem_req_valid), 64'd0);
        fetch(64'h8000_0400, 0, 1, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
